regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_if.sv | 39 +++
 rtl/regfile_writeback.sv | 191 +++++++++++++++++++
 tb/tb_regfile_writeback.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Writeback bus between the execute/load units and the register file.
// master = pipeline side driving results, slave = writeback block.
interface regfile_writeback_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic        err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output rsv_valid, rsv_rd,
        output rs1_addr, rs2_addr,
        input  lsu_ready, rs1_busy, rs2_busy,
        input  rd_addr, rd_data, wr_en, err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  rsv_valid, rsv_rd,
        input  rs1_addr, rs2_addr,
        output lsu_ready, rs1_busy, rs2_busy,
        output rd_addr, rd_data, wr_en, err
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file writeback: ALU-priority merge of ALU and buffered load
// results, plus a load-pending scoreboard for decode hazard checks.
module regfile_writeback_core #(
    parameter int LSU_DEPTH = 2
) (
    input logic                clk_i,
    input logic                rst_ni,
    regfile_writeback_if.slave bus
);
    localparam int PW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;

    logic [4:0]  fifo_rd_q   [LSU_DEPTH];
    logic [31:0] fifo_data_q [LSU_DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    logic [31:0] busy_q, busy_d;
    logic        err_q, err_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        live_q;

    logic        ready;
    logic        push;
    logic        pop;
    logic        alu_sel;
    logic        set;
    logic        clr;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    assign ready     = cnt_q < (PW+1)'(LSU_DEPTH);
    assign push      = bus.lsu_valid && ready;
    assign pop       = !bus.alu_valid && (cnt_q != '0);
    assign head_rd   = fifo_rd_q[rptr_q];
    assign head_data = fifo_data_q[rptr_q];

    // Block ALU writes on the first edge out of reset.
    assign alu_sel = bus.alu_valid && live_q;

    assign set = bus.rsv_valid && (bus.rsv_rd != 5'd0);
    assign clr = pop && (head_rd != 5'd0);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        unique case (1'b1)
            alu_sel: begin
                wr_en_d   = bus.alu_rd != 5'd0;
                rd_addr_d = bus.alu_rd;
                rd_data_d = bus.alu_data;
            end
            pop: begin
                wr_en_d   = head_rd != 5'd0;
                rd_addr_d = head_rd;
                rd_data_d = head_data;
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase
    end

    // A reservation landing on the register being cleared is legal.
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (clr) begin
            busy_d[head_rd] = 1'b0;
        end
        if (set) begin
            busy_d[bus.rsv_rd] = 1'b1;
            if (busy_q[bus.rsv_rd] && !(clr && head_rd == bus.rsv_rd)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            live_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            live_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= bus.lsu_rd;
            fifo_data_q[wptr_q] <= bus.lsu_data;
        end
    end

    assign bus.lsu_ready = ready;
    assign bus.rs1_busy  = (bus.rs1_addr != 5'd0) && busy_q[bus.rs1_addr];
    assign bus.rs2_busy  = (bus.rs2_addr != 5'd0) && busy_q[bus.rs2_addr];
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.err       = err_q;
endmodule

module regfile_writeback #(
    parameter int LSU_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        alu_valid_in,
    input  logic [4:0]  alu_rd_in,
    input  logic [31:0] alu_data_in,
    input  logic        lsu_valid_in,
    input  logic [4:0]  lsu_rd_in,
    input  logic [31:0] lsu_data_in,
    output logic        lsu_ready_out,
    input  logic        rsv_valid_in,
    input  logic [4:0]  rsv_rd_in,
    input  logic [4:0]  rs_1_addr_in,
    input  logic [4:0]  rs_2_addr_in,
    output logic        rs_1_busy_out,
    output logic        rs_2_busy_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_out,
    output logic        wr_en_out,
    output logic        err_out
);
    regfile_writeback_if bus ();

    assign bus.alu_valid = alu_valid_in;
    assign bus.alu_rd    = alu_rd_in;
    assign bus.alu_data  = alu_data_in;
    assign bus.lsu_valid = lsu_valid_in;
    assign bus.lsu_rd    = lsu_rd_in;
    assign bus.lsu_data  = lsu_data_in;
    assign bus.rsv_valid = rsv_valid_in;
    assign bus.rsv_rd    = rsv_rd_in;
    assign bus.rs1_addr  = rs_1_addr_in;
    assign bus.rs2_addr  = rs_2_addr_in;

    assign lsu_ready_out = bus.lsu_ready;
    assign rs_1_busy_out = bus.rs1_busy;
    assign rs_2_busy_out = bus.rs2_busy;
    assign rd_addr_out   = bus.rd_addr;
    assign rd_out        = bus.rd_data;
    assign wr_en_out     = bus.wr_en;
    assign err_out       = bus.err;

    regfile_writeback_core #(
        .LSU_DEPTH(LSU_DEPTH)
    ) u_core (
        .clk_i (clk_in),
        .rst_ni(rst_n_in),
        .bus   (bus.slave)
    );
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: scoreboard of expected register writes
// built from a reference FIFO model, plus directed timing checks.
module tb_regfile_writeback;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   mon_en;
    wb_t  sb[$];
    wb_t  lq[$];

    regfile_writeback_if bus ();

    regfile_writeback #(
        .LSU_DEPTH(DEPTH)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .alu_valid_in (bus.alu_valid),
        .alu_rd_in    (bus.alu_rd),
        .alu_data_in  (bus.alu_data),
        .lsu_valid_in (bus.lsu_valid),
        .lsu_rd_in    (bus.lsu_rd),
        .lsu_data_in  (bus.lsu_data),
        .lsu_ready_out(bus.lsu_ready),
        .rsv_valid_in (bus.rsv_valid),
        .rsv_rd_in    (bus.rsv_rd),
        .rs_1_addr_in (bus.rs1_addr),
        .rs_2_addr_in (bus.rs2_addr),
        .rs_1_busy_out(bus.rs1_busy),
        .rs_2_busy_out(bus.rs2_busy),
        .rd_addr_out  (bus.rd_addr),
        .rd_out       (bus.rd_data),
        .wr_en_out    (bus.wr_en),
        .err_out      (bus.err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        wb_t e;
        if (mon_en && bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("wb_rd", 32'(bus.rd_addr), 32'(e.rd));
                chk("wb_data", bus.rd_data, e.data);
            end
        end
    end

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_data  = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_rd    = '0;
    endtask

    // Reference model: ALU first, else FIFO head; accept uses pre-edge fill.
    task automatic step();
        wb_t e;
        bit  acc;
        acc = bus.lsu_valid && (lq.size() < DEPTH);
        if (bus.alu_valid) begin
            e.rd   = bus.alu_rd;
            e.data = bus.alu_data;
            if (e.rd != 0) sb.push_back(e);
        end else if (lq.size() != 0) begin
            e = lq.pop_front();
            if (e.rd != 0) sb.push_back(e);
        end
        if (acc) begin
            e.rd   = bus.lsu_rd;
            e.data = bus.lsu_data;
            lq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        idle();
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;

        #12;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_rd_addr", 32'(bus.rd_addr), 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_ready", bus.lsu_ready, 1);
        chk("rst_err", bus.err, 0);
        chk("rst_busy1", bus.rs1_busy, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // ALU path
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEAD_BEEF;
        step();
        idle();
        @(negedge clk);
        chk("alu_wr_n1", bus.wr_en, 1);
        chk("alu_rd_n1", 32'(bus.rd_addr), 5);
        step();
        @(negedge clk);
        chk("alu_wr_n2", bus.wr_en, 0);

        // Load with reservation
        bus.rsv_valid = 1'b1;
        bus.rsv_rd    = 5'd7;
        bus.rs1_addr  = 5'd7;
        step();
        bus.rsv_valid = 1'b0;
        @(negedge clk);
        chk("busy7_set", bus.rs1_busy, 1);
        step();
        step();
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd7;
        bus.lsu_data  = 32'h1234_5678;
        @(negedge clk);
        chk("ld_ready", bus.lsu_ready, 1);
        step();
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        chk("ld_wr_n4", bus.wr_en, 0);
        chk("busy7_n4", bus.rs1_busy, 1);
        step();
        @(negedge clk);
        chk("ld_wr_n5", bus.wr_en, 1);
        chk("busy7_n5", bus.rs1_busy, 0);
        step();

        // Contention and backpressure
        for (int i = 0; i < 5; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(16 + i);
            bus.alu_data  = 32'hA000_0000 + 32'(i);
            bus.lsu_valid = i < 3;
            bus.lsu_rd    = 5'(11 + ((i < 2) ? i : 2));
            bus.lsu_data  = 32'hB000_0001 + 32'((i < 2) ? i : 2);
            @(negedge clk);
            chk("bp_ready", bus.lsu_ready, (i < 2) ? 1 : 0);
            step();
        end
        idle();
        @(negedge clk);
        chk("drain_ready0", bus.lsu_ready, 0);
        step();
        @(negedge clk);
        chk("drain_wr1", bus.wr_en, 1);
        chk("drain_rd1", 32'(bus.rd_addr), 11);
        chk("drain_ready1", bus.lsu_ready, 1);
        step();
        @(negedge clk);
        chk("drain_wr2", bus.wr_en, 1);
        chk("drain_rd2", 32'(bus.rd_addr), 12);
        step();
        @(negedge clk);
        chk("drain_wr3", bus.wr_en, 0);
        chk("drain_ready3", bus.lsu_ready, 1);

        // x0 handling
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'hCAFE_0000;
        step();
        idle();
        @(negedge clk);
        chk("x0_alu_wr", bus.wr_en, 0);
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd0;
        bus.lsu_data  = 32'h1111_1111;
        step();
        bus.lsu_rd    = 5'd4;
        bus.lsu_data  = 32'h4444_4444;
        step();
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        chk("x0_ld_wr", bus.wr_en, 0);
        step();
        @(negedge clk);
        chk("x0_next_wr", bus.wr_en, 1);
        chk("x0_next_rd", 32'(bus.rd_addr), 4);
        bus.rsv_valid = 1'b1;
        bus.rsv_rd    = 5'd0;
        bus.rs1_addr  = 5'd0;
        step();
        step();
        bus.rsv_valid = 1'b0;
        @(negedge clk);
        chk("x0_busy", bus.rs1_busy, 0);
        chk("x0_err", bus.err, 0);

        // Same-cycle set/clear, then double reservation
        bus.rs1_addr  = 5'd9;
        bus.rsv_valid = 1'b1;
        bus.rsv_rd    = 5'd9;
        step();
        bus.rsv_valid = 1'b0;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd9;
        bus.lsu_data  = 32'h9999_0009;
        step();
        bus.lsu_valid = 1'b0;
        bus.rsv_valid = 1'b1;
        step();
        bus.rsv_valid = 1'b0;
        @(negedge clk);
        chk("sc_busy9", bus.rs1_busy, 1);
        chk("sc_err", bus.err, 0);
        chk("sc_wr", bus.wr_en, 1);
        bus.rsv_valid = 1'b1;
        step();
        bus.rsv_valid = 1'b0;
        @(negedge clk);
        chk("dbl_err", bus.err, 1);
        step();
        @(negedge clk);
        chk("dbl_err_sticky", bus.err, 1);

        // Reset mid-operation
        bus.rs1_addr  = 5'd3;
        bus.rs2_addr  = 5'd3;
        bus.rsv_valid = 1'b1;
        bus.rsv_rd    = 5'd3;
        step();
        bus.rsv_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(25 + i);
            bus.alu_data  = 32'hC000_0000 + 32'(i);
            bus.lsu_valid = i < 2;
            bus.lsu_rd    = 5'(20 + i);
            bus.lsu_data  = 32'hD000_0000 + 32'(i);
            step();
        end
        idle();
        chk("pre_rst_busy", bus.rs1_busy, 1);
        chk("pre_rst_ready", bus.lsu_ready, 0);
        chk("pre_rst_wr", bus.wr_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", bus.wr_en, 0);
        chk("mid_rst_ready", bus.lsu_ready, 1);
        chk("mid_rst_busy1", bus.rs1_busy, 0);
        chk("mid_rst_busy2", bus.rs2_busy, 0);
        chk("mid_rst_err", bus.err, 0);
        sb.delete();
        lq.delete();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("post_rst_wr", bus.wr_en, 0);
        end
        chk("post_rst_ready", bus.lsu_ready, 1);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
